// File: rtl/regfile_mp.sv
// Multi-read-port register file for the MIPS ID stage: synchronous write with
// optional write-to-read bypass, optional hardwired zero entry, sequenced clear.
module regfile_mp #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       reg_write,
  input  logic [ADDR_W-1:0]          wreg,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       clr,
  input  logic [NUM_RD*ADDR_W-1:0]   rreg,
  output logic [NUM_RD*WIDTH-1:0]    rdata,
  output logic                       busy,
  output logic                       wr_drop
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CLR_START = ZERO_REG ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic wr_en_c;
  logic drop_c;

  // Entry 0 is never written when it is hardwired; that case is not a drop.
  assign wr_en_c = (state == IDLE) && reg_write && !clr && !(ZERO_REG && (wreg == '0));
  assign drop_c  = reg_write && (busy || clr);

  // Control FSM: clear sequencing, busy and the one-cycle drop pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= CLR_START;
      busy    <= 1'b1;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= drop_c;
      if (clr) begin
        state   <= CLEAR;
        clr_ptr <= CLR_START;
        busy    <= 1'b1;
      end else if (state == CLEAR) begin
        clr_ptr <= clr_ptr + ADDR_W'(1);
        if (clr_ptr == CLR_LAST) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

  // Storage array: not reset; the clear engine zeroes it one entry per edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (wr_en_c) begin
        mem[wreg] <= wdata;
      end
    end
  end

  // Independent combinational read ports.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [WIDTH-1:0]  rd_c;

    assign ra = rreg[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_c = mem[ra];
      if (busy) begin
        rd_c = '0;
      end else if (ZERO_REG && (ra == '0)) begin
        rd_c = '0;
      end else if (BYPASS && reg_write && !clr && (wreg == ra)) begin
        rd_c = wdata;
      end
    end

    assign rdata[k*WIDTH +: WIDTH] = rd_c;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (zero-reg+bypass, and neither) against a
// behavioural model checked every cycle, plus hand-computed directed checks.
module tb_regfile_mp;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 3;
  localparam int unsigned D  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              reg_write;
  logic              clr;
  logic [AW-1:0]     wreg;
  logic [W-1:0]      wdata;
  logic [NR*AW-1:0]  rreg;
  logic [NR*W-1:0]   rd0, rd1;
  logic              busy0, busy1, drop0, drop1;

  regfile_mp #(.WIDTH(W), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .wreg(wreg), .wdata(wdata),
    .clr(clr), .rreg(rreg), .rdata(rd0), .busy(busy0), .wr_drop(drop0)
  );

  regfile_mp #(.WIDTH(W), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b0), .BYPASS(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .wreg(wreg), .wdata(wdata),
    .clr(clr), .rreg(rreg), .rdata(rd1), .busy(busy1), .wr_drop(drop1)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] sl(input logic [NR*W-1:0] v, input int k);
    return v[k*W +: W];
  endfunction

  // Model: config 0 = zero-reg + bypass, config 1 = plain. A clear is a
  // countdown of edges; when it expires every entry is zero.
  logic [W-1:0] mm [2][D];
  int           rem [2];
  bit           mdrop [2];
  bit           mvalid = 1'b0;

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        rem[c]   = (c == 0) ? 31 : 32;
        mdrop[c] = 1'b0;
      end else begin
        mdrop[c] = reg_write && ((rem[c] > 0) || clr);
        if (clr) begin
          rem[c] = (c == 0) ? 31 : 32;
        end else if (rem[c] > 0) begin
          rem[c]--;
          if (rem[c] == 0)
            for (int a = 0; a < int'(D); a++) mm[c][a] = '0;
        end else if (reg_write && !((c == 0) && (wreg == '0))) begin
          mm[c][wreg] = wdata;
        end
      end
    end
    if (!rst_n) mvalid = 1'b1;
  end

  function automatic logic [W-1:0] exp_rd(input int c, input logic [AW-1:0] a);
    if (rem[c] > 0) return '0;
    if ((c == 0) && (a == '0)) return '0;
    if ((c == 0) && reg_write && !clr && (wreg == a)) return wdata;
    return mm[c][a];
  endfunction

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("busy0", 32'(busy0), 32'(rem[0] > 0));
      chk("busy1", 32'(busy1), 32'(rem[1] > 0));
      chk("drop0", 32'(drop0), 32'(mdrop[0]));
      chk("drop1", 32'(drop1), 32'(mdrop[1]));
      for (int k = 0; k < int'(NR); k++) begin
        chk($sformatf("u0_rd%0d", k), sl(rd0, k), exp_rd(0, rreg[k*AW +: AW]));
        chk($sformatf("u1_rd%0d", k), sl(rd1, k), exp_rd(1, rreg[k*AW +: AW]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until each instance leaves busy; bounded.
  task automatic wait_idle(input string name, input int x0, input int x1);
    int e0 = 0;
    int e1 = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (!busy0 && e0 == 0) e0 = i;
      if (!busy1 && e1 == 0) e1 = i;
    end
    chk({name, "_len0"}, 32'(e0), 32'(x0));
    chk({name, "_len1"}, 32'(e1), 32'(x1));
  endtask

  initial begin
    rst_n = 1'b0; reg_write = 1'b0; clr = 1'b0;
    wreg = '0; wdata = '0; rreg = '0;

    // Reset, then the full clear
    repeat (2) tick();
    chk("rst_busy0", 32'(busy0), 32'd1);
    chk("rst_drop0", 32'(drop0), 32'd0);
    rst_n = 1'b1;
    wait_idle("reset_clear", 31, 32);
    for (int a = 0; a < int'(D); a++) begin
      rreg = {3{5'(a)}};
      #1;
      chk("clr_u0", sl(rd0, 0), 32'h0);
      chk("clr_u1", sl(rd1, 2), 32'h0);
      tick();
    end

    // Write and read back on three ports
    reg_write = 1'b1;
    wreg = 5'd1; wdata = 32'h002300AA; tick();
    wreg = 5'd2; wdata = 32'h10654321; tick();
    wreg = 5'd3; wdata = 32'h8C123456; tick();
    reg_write = 1'b0;
    rreg = {5'd3, 5'd2, 5'd1};
    #1;
    chk("wr_u0_p0", sl(rd0, 0), 32'h002300AA);
    chk("wr_u0_p1", sl(rd0, 1), 32'h10654321);
    chk("wr_u0_p2", sl(rd0, 2), 32'h8C123456);
    chk("wr_u1_p1", sl(rd1, 1), 32'h10654321);
    rreg = {3{5'd2}};
    #1;
    chk("same_p0", sl(rd0, 0), 32'h10654321);
    chk("same_p2", sl(rd0, 2), 32'h10654321);
    tick();

    // Bypass vs no bypass
    reg_write = 1'b1; wreg = 5'd5; wdata = 32'hAD654321;
    rreg = {5'd0, 5'd0, 5'd5};
    #1;
    chk("byp_u0", sl(rd0, 0), 32'hAD654321);
    chk("nobyp_u1_old", sl(rd1, 0), 32'h0);
    tick();
    reg_write = 1'b0;
    #1;
    chk("nobyp_u1_new", sl(rd1, 0), 32'hAD654321);
    chk("byp_u0_after", sl(rd0, 0), 32'hAD654321);

    // Zero register
    reg_write = 1'b1; wreg = 5'd0; wdata = 32'hFFFFFFFF;
    rreg = {3{5'd0}};
    #1;
    chk("zr_u0_same", sl(rd0, 0), 32'h0);
    chk("zr_u1_same", sl(rd1, 0), 32'h0);
    tick();
    reg_write = 1'b0;
    #1;
    chk("zr_u0", sl(rd0, 0), 32'h0);
    chk("nozr_u1", sl(rd1, 0), 32'hFFFFFFFF);
    chk("zr_drop0", 32'(drop0), 32'd0);
    chk("zr_drop1", 32'(drop1), 32'd0);

    // Write dropped while busy
    clr = 1'b1; tick();
    clr = 1'b0;
    reg_write = 1'b1; wreg = 5'd7; wdata = 32'hAC654321;
    tick();
    reg_write = 1'b0;
    chk("busy_drop0", 32'(drop0), 32'd1);
    chk("busy_drop1", 32'(drop1), 32'd1);
    tick();
    chk("busy_drop0_end", 32'(drop0), 32'd0);
    wait_idle("busy_wr", 29, 30);
    rreg = {3{5'd7}};
    #1;
    chk("r7_u0", sl(rd0, 0), 32'h0);
    chk("r7_u1", sl(rd1, 1), 32'h0);

    // clr together with a write
    reg_write = 1'b1; wreg = 5'd8; wdata = 32'h5A5A5A5A; tick();
    wdata = 32'hAC654321; clr = 1'b1; tick();
    reg_write = 1'b0; clr = 1'b0;
    rreg = {3{5'd8}};
    chk("clrwr_drop0", 32'(drop0), 32'd1);
    chk("clrwr_busy0", 32'(busy0), 32'd1);
    wait_idle("clr_wr", 31, 32);
    chk("r8_u0", sl(rd0, 0), 32'h0);
    chk("r8_u1", sl(rd1, 2), 32'h0);

    // Reset in the middle of a clear
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_busy0", 32'(busy0), 32'd1);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    wait_idle("mid_rst", 31, 32);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
